// File: rtl/eth_tx_sched_if.sv
// Signal bundle between the GMII TX frame scheduler and its requesters and framer.
// The master side is the scheduler. The slave side is the surrounding logic.
interface eth_tx_sched_if;
    logic        arp_req;
    logic [47:0] arp_req_mac;
    logic        udp_frame_rdy;
    logic        tx_done;
    logic        tx_start;
    logic        tx_sel;
    logic [47:0] tx_dst_mac;
    logic        arp_drop;
    logic        timeout_err;
    logic        sched_idle;

    modport master (
        input  arp_req, arp_req_mac, udp_frame_rdy, tx_done,
        output tx_start, tx_sel, tx_dst_mac, arp_drop, timeout_err, sched_idle
    );

    modport slave (
        output arp_req, arp_req_mac, udp_frame_rdy, tx_done,
        input  tx_start, tx_sel, tx_dst_mac, arp_drop, timeout_err, sched_idle
    );
endinterface

// File: rtl/eth_tx_sched.sv
// Frame-level scheduler sharing the GMII TX framer between ARP replies and UDP frames.
// ARP has priority, bounded by a burst limit. A watchdog recovers a hung framer.
module eth_tx_sched #(
    parameter int IFG_CYCLES     = 12,
    parameter int MAX_ARP_BURST  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           aclk,
    input  logic           areset,
    eth_tx_sched_if.master bus
);
    localparam int CNT_W = $clog2(MAX_ARP_BURST + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = $clog2(IFG_CYCLES + 1);
    localparam logic [CNT_W-1:0] ARP_MAX  = CNT_W'(MAX_ARP_BURST);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic               grant_arp_s;
    logic               grant_udp_s;
    logic               expire_s;
    logic               arp_pend_r;
    logic [47:0]        arp_mac_r;
    logic [CNT_W-1:0]   arp_cnt_r;
    logic [WD_W-1:0]    wdog_r;
    logic [GAP_W-1:0]   gap_r;
    logic               tx_start_r;
    logic               tx_sel_r;
    logic [47:0]        tx_dst_mac_r;
    logic               arp_drop_r;
    logic               timeout_err_r;
    logic               sched_idle_r;

    // Next-state decode, grant arbitration and watchdog expiry
    always_comb begin
        state_next_s = state_r;
        grant_arp_s  = 1'b0;
        grant_udp_s  = 1'b0;
        expire_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                grant_arp_s = arp_pend_r && !(bus.udp_frame_rdy && (arp_cnt_r == ARP_MAX));
                grant_udp_s = !grant_arp_s && bus.udp_frame_rdy;
                if (grant_arp_s || grant_udp_s) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                state_next_s = ST_BUSY;
            end
            ST_BUSY: begin
                // A done pulse on the expiry cycle still counts as a clean finish
                if (bus.tx_done) begin
                    state_next_s = ST_GAP;
                end else if (wdog_r == WD_LAST) begin
                    state_next_s = ST_GAP;
                    expire_s     = 1'b1;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_GAP: begin
                if (gap_r == GAP_LAST) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_GAP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register, watchdog and inter-frame gap counters
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_r <= ST_IDLE;
            wdog_r  <= '0;
            gap_r   <= '0;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_BUSY) begin
                wdog_r <= wdog_r + WD_W'(1);
            end else begin
                wdog_r <= '0;
            end
            if (state_r == ST_GAP) begin
                gap_r <= gap_r + GAP_W'(1);
            end else begin
                gap_r <= '0;
            end
        end
    end

    // One-deep ARP request holder and consecutive-ARP burst counter
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arp_pend_r <= 1'b0;
            arp_mac_r  <= 48'd0;
            arp_cnt_r  <= '0;
        end else begin
            if (bus.arp_req) begin
                arp_pend_r <= 1'b1;
                arp_mac_r  <= bus.arp_req_mac;
            end else if (grant_arp_s) begin
                arp_pend_r <= 1'b0;
            end
            if (grant_arp_s && (arp_cnt_r != ARP_MAX)) begin
                arp_cnt_r <= arp_cnt_r + CNT_W'(1);
            end else if (grant_udp_s) begin
                arp_cnt_r <= '0;
            end
        end
    end

    // Registered outputs; the grant reads the MAC held before any same-cycle request
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tx_start_r    <= 1'b0;
            tx_sel_r      <= 1'b0;
            tx_dst_mac_r  <= 48'd0;
            arp_drop_r    <= 1'b0;
            timeout_err_r <= 1'b0;
            sched_idle_r  <= 1'b1;
        end else begin
            tx_start_r    <= (state_next_s == ST_START);
            arp_drop_r    <= bus.arp_req && arp_pend_r && !grant_arp_s;
            timeout_err_r <= expire_s;
            sched_idle_r  <= (state_next_s == ST_IDLE);
            if (grant_arp_s) begin
                tx_sel_r     <= 1'b1;
                tx_dst_mac_r <= arp_mac_r;
            end else if (grant_udp_s) begin
                tx_sel_r <= 1'b0;
            end
        end
    end

    assign bus.tx_start    = tx_start_r;
    assign bus.tx_sel      = tx_sel_r;
    assign bus.tx_dst_mac  = tx_dst_mac_r;
    assign bus.arp_drop    = arp_drop_r;
    assign bus.timeout_err = timeout_err_r;
    assign bus.sched_idle  = sched_idle_r;
endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus queues the expected grants and a monitor
// checks each tx_start against them. A behavioural framer answers with tx_done.
module tb_eth_tx_sched;
    typedef struct {
        logic        sel;
        logic [47:0] mac;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_dly = 0;
    int   drop_cnt = 0;
    int   to_cnt = 0;
    int   to_cyc = -1;
    exp_t exp_q[$];
    exp_t e_mon;

    eth_tx_sched_if bus ();

    eth_tx_sched #(
        .IFG_CYCLES    (12),
        .MAX_ARP_BURST (4),
        .TIMEOUT_CYCLES(4096)
    ) dut (
        .aclk  (clk),
        .areset(rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every tx_start pops one expected grant
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.tx_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", 64'd1, 64'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("grant_sel", {63'd0, bus.tx_sel}, {63'd0, e_mon.sel});
                    chk("grant_mac", {16'd0, bus.tx_dst_mac}, {16'd0, e_mon.mac});
                    if (e_mon.cyc >= 0) chk("grant_cycle", 64'(cyc), 64'(e_mon.cyc));
                end
            end
            if (bus.arp_drop) drop_cnt++;
            if (bus.timeout_err) begin
                to_cnt++;
                to_cyc = cyc;
            end
        end
    end

    // Behavioural framer: tx_done done_dly cycles after tx_start (0 = hung)
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && bus.tx_start && done_dly > 0) begin
                repeat (done_dly) @(posedge clk);
                #1 bus.tx_done = 1'b1;
                @(posedge clk);
                #1 bus.tx_done = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        int n = 0;
        while (cyc < c && n < 20000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic pulse_arp(input logic [47:0] m);
        bus.arp_req     = 1'b1;
        bus.arp_req_mac = m;
        tick(1);
        bus.arp_req     = 1'b0;
    endtask

    task automatic push_exp(input logic s, input logic [47:0] m, input int c);
        exp_t e;
        e.sel = s;
        e.mac = m;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(bus.sched_idle && exp_q.size() == 0) && n < budget) begin
            tick(1);
            n++;
        end
        chk("idle_wait", {63'd0, (n < budget)}, 64'd1);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        @(negedge clk);
        while (!bus.tx_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("start_wait", {63'd0, (n < budget)}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int          c0;
        int          s0;
        int          jreq;
        int          j;
        logic        sel;
        logic [47:0] last_mac;
        logic [47:0] lm;
        logic [47:0] base;

        rst               = 1'b1;
        bus.arp_req       = 1'b0;
        bus.arp_req_mac   = 48'd0;
        bus.udp_frame_rdy = 1'b0;
        tick(3);
        chk("rst_tx_start", {63'd0, bus.tx_start}, 64'd0);
        chk("rst_tx_sel", {63'd0, bus.tx_sel}, 64'd0);
        chk("rst_tx_dst_mac", {16'd0, bus.tx_dst_mac}, 64'd0);
        chk("rst_arp_drop", {63'd0, bus.arp_drop}, 64'd0);
        chk("rst_timeout_err", {63'd0, bus.timeout_err}, 64'd0);
        chk("rst_sched_idle", {63'd0, bus.sched_idle}, 64'd1);
        rst = 1'b0;
        tick(2);

        // ARP alone: start two cycles after the request, idle 12 cycles after done
        done_dly = 5;
        c0 = cyc;
        push_exp(1'b1, 48'h020000000001, c0 + 2);
        pulse_arp(48'h020000000001);
        wait_cycle(c0 + 2 + 5 + 12);
        chk("t1_idle_in_gap", {63'd0, bus.sched_idle}, 64'd0);
        tick(1);
        chk("t1_idle_after_gap", {63'd0, bus.sched_idle}, 64'd1);
        last_mac = 48'h020000000001;

        // ARP pending together with UDP ready: ARP first, UDP after the gap
        c0 = cyc;
        push_exp(1'b1, 48'h020000000002, c0 + 2);
        push_exp(1'b0, 48'h020000000002, c0 + 21);
        bus.arp_req     = 1'b1;
        bus.arp_req_mac = 48'h020000000002;
        tick(1);
        bus.arp_req       = 1'b0;
        bus.udp_frame_rdy = 1'b1;
        wait_cycle(c0 + 21);
        bus.udp_frame_rdy = 1'b0;
        wait_idle(200);
        last_mac = 48'h020000000002;

        // Starvation bound: ARP x4, UDP, ARP x4, UDP, ARP
        done_dly = 3;
        base = 48'h0A0000000000;
        lm = last_mac;
        j = 0;
        for (int k = 0; k < 11; k++) begin
            if (k == 4 || k == 9) begin
                push_exp(1'b0, lm, -1);
            end else begin
                lm = base + 48'(j);
                push_exp(1'b1, lm, -1);
                j++;
            end
        end
        pulse_arp(base);
        bus.udp_frame_rdy = 1'b1;
        jreq = 1;
        for (int k = 0; k < 11; k++) begin
            wait_start(200);
            sel = !(k == 4 || k == 9);
            if (sel && jreq < 9) begin
                tick(1);
                pulse_arp(base + 48'(jreq));
                jreq++;
            end
            if (k == 10) begin
                tick(1);
                bus.udp_frame_rdy = 1'b0;
            end
        end
        wait_idle(200);
        chk("t3_no_drop", 64'(drop_cnt), 64'd0);
        last_mac = base + 48'd8;

        // Overwrite during BUSY: one drop, newest MAC granted once
        done_dly = 10;
        c0 = cyc;
        bus.udp_frame_rdy = 1'b1;
        push_exp(1'b0, last_mac, c0 + 1);
        push_exp(1'b1, 48'h0B00000000BB, c0 + 25);
        tick(1);
        bus.udp_frame_rdy = 1'b0;
        tick(1);
        pulse_arp(48'h0A00000000AA);
        tick(1);
        pulse_arp(48'h0B00000000BB);
        wait_idle(200);
        tick(20);
        chk("t4_drop_count", 64'(drop_cnt), 64'd1);
        chk("t4_single_arp", 64'(exp_q.size()), 64'd0);
        last_mac = 48'h0B00000000BB;

        // Watchdog: hung framer aborts after 4096 BUSY cycles
        done_dly = 0;
        c0 = cyc;
        s0 = c0 + 1;
        bus.udp_frame_rdy = 1'b1;
        push_exp(1'b0, last_mac, s0);
        tick(1);
        bus.udp_frame_rdy = 1'b0;
        wait_cycle(s0 + 4096 + 12);
        chk("t5_idle_in_gap", {63'd0, bus.sched_idle}, 64'd0);
        tick(1);
        chk("t5_idle_after_gap", {63'd0, bus.sched_idle}, 64'd1);
        chk("t5_timeout_count", 64'(to_cnt), 64'd1);
        chk("t5_timeout_cycle", 64'(to_cyc), 64'(s0 + 4097));

        // Watchdog variant: done on the expiry cycle wins
        done_dly = 4096;
        c0 = cyc;
        s0 = c0 + 1;
        bus.udp_frame_rdy = 1'b1;
        push_exp(1'b0, last_mac, s0);
        tick(1);
        bus.udp_frame_rdy = 1'b0;
        wait_cycle(s0 + 4096 + 13);
        chk("t5b_idle", {63'd0, bus.sched_idle}, 64'd1);
        chk("t5b_no_timeout", 64'(to_cnt), 64'd1);

        // Async reset in BUSY with a request pending
        done_dly = 0;
        c0 = cyc;
        push_exp(1'b1, 48'h0C000000000C, c0 + 2);
        pulse_arp(48'h0C000000000C);
        tick(2);
        pulse_arp(48'h0D000000000D);
        #3 rst = 1'b1;
        #1;
        chk("t6_tx_start", {63'd0, bus.tx_start}, 64'd0);
        chk("t6_tx_sel", {63'd0, bus.tx_sel}, 64'd0);
        chk("t6_tx_dst_mac", {16'd0, bus.tx_dst_mac}, 64'd0);
        chk("t6_arp_drop", {63'd0, bus.arp_drop}, 64'd0);
        chk("t6_timeout_err", {63'd0, bus.timeout_err}, 64'd0);
        chk("t6_sched_idle", {63'd0, bus.sched_idle}, 64'd1);
        tick(2);
        rst = 1'b0;
        tick(30);
        chk("t6_no_restart", 64'(exp_q.size()), 64'd0);
        done_dly = 4;
        c0 = cyc;
        push_exp(1'b1, 48'h0E000000000E, c0 + 2);
        pulse_arp(48'h0E000000000E);
        wait_idle(100);

        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
